// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM request arbiter: FSM encoding and device constants.
package eeprom_pkg;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StArb   = 6'b000010,
    StIssue = 6'b000100,
    StWait  = 6'b001000,
    StDone  = 6'b010000,
    StAbort = 6'b100000
  } arb_state_e;

  localparam logic [3:0]  EE_DEV_CODE     = 4'b1010;
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: one-hot grant from the lowest request at or after the
// pointer, with the pointer moving past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx, hi_idx, lo_idx;
  logic          hi_found, lo_found;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan: the last hit is the lowest index, both overall and at/after ptr.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
        lo_found = 1'b1;
        lo_idx   = PW'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;

    gnt = '0;
    if (lo_found) gnt[win_idx] = 1'b1;

    ptr_d = ptr_q;
    if (advance && lo_found) begin
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/eeprom_arbiter.sv
// Shares one EEPROM serial controller between NREQ clients: round-robin grant, one-cycle
// strobe, held command until ACK, watchdog abort with controller reset.
module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 11,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  RNW,
  input  logic [NREQ*AW-1:0] ADDR_IN,
  input  logic [NREQ*8-1:0] WDATA_IN,
  output logic [NREQ-1:0]  GNT,
  output logic [NREQ-1:0]  DONE,
  output logic             ERR,
  output logic [7:0]       RDATA,
  output logic             EE_WR,
  output logic             EE_RD,
  output logic [AW-1:0]    EE_ADDR,
  output logic [7:0]       EE_WDATA,
  output logic             EE_DOE,
  input  logic [7:0]       EE_RDATA,
  input  logic             EE_ACK,
  output logic             EE_RST
);

  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rnw_q, rnw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;
  logic            abort_cnt_q, abort_cnt_d;
  logic            ee_rst_q, ee_rst_d;

  logic [NREQ-1:0] arb_gnt;
  logic            arb_advance;
  logic            sel_rnw;
  logic [AW-1:0]   sel_addr;
  logic [7:0]      sel_wdata;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (REQ),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  always_comb begin
    sel_rnw   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_rnw   = RNW[i];
        sel_addr  = ADDR_IN[i*AW +: AW];
        sel_wdata = WDATA_IN[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wd_d        = wd_q;
    err_d       = err_q;
    abort_cnt_d = abort_cnt_q;
    arb_advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|REQ) state_d = StArb;
      end
      StArb: begin
        if (|REQ) begin
          gnt_d       = arb_gnt;
          rnw_d       = sel_rnw;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          arb_advance = 1'b1;
          state_d     = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        wd_d    = '0;
        err_d   = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        if (wd_q != {WDW{1'b1}}) wd_d = wd_q + 1'b1;
        if (EE_ACK) begin
          if (rnw_q) rdata_d = EE_RDATA;
          state_d = StDone;
        end else if (wd_q >= WDW'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          abort_cnt_d = 1'b0;
          state_d     = StAbort;
        end
      end
      StAbort: begin
        // Two cycles of controller reset before reporting the failure.
        if (abort_cnt_q) state_d = StDone;
        else             abort_cnt_d = 1'b1;
      end
      StDone: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ee_rst_d = (state_d == StAbort);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      abort_cnt_q <= 1'b0;
      ee_rst_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      abort_cnt_q <= abort_cnt_d;
      ee_rst_q    <= ee_rst_d;
    end
  end

  // The grant is already visible in the arbitration cycle.
  assign GNT      = gnt_q | ((state_q == StArb) ? arb_gnt : '0);
  assign DONE     = (state_q == StDone) ? gnt_q : '0;
  assign ERR      = (state_q == StDone) && err_q;
  assign RDATA    = rdata_q;
  assign EE_WR    = (state_q == StIssue) && !rnw_q;
  assign EE_RD    = (state_q == StIssue) && rnw_q;
  assign EE_ADDR  = addr_q;
  assign EE_WDATA = wdata_q;
  assign EE_DOE   = ((state_q == StIssue) || (state_q == StWait)) && !rnw_q;
  assign EE_RST   = ee_rst_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed plus randomized bench for eeprom_arbiter with a behavioural EEPROM and a
// round-robin reference model.
module tb_eeprom_arbiter;
  import eeprom_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 11;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [1:0]  rnw;
  logic [21:0] addr_in;
  logic [15:0] wdata_in;
  logic [1:0]  gnt, done;
  logic        err;
  logic [7:0]  rdata;
  logic        ee_wr, ee_rd, ee_doe, ee_rst;
  logic [10:0] ee_addr;
  logic [7:0]  ee_wdata;
  logic [7:0]  ee_rdata;
  logic        ee_ack;

  bit          c_rnw   [2];
  logic [10:0] c_addr  [2];
  logic [7:0]  c_wdata [2];
  logic [7:0]  mem [0:2047];
  int          ptr_m;
  logic [7:0]  exp_rdata;
  int          checks = 0;
  int          errors = 0;

  assign rnw      = {c_rnw[1], c_rnw[0]};
  assign addr_in  = {c_addr[1], c_addr[0]};
  assign wdata_in = {c_wdata[1], c_wdata[0]};

  always #5 clk = ~clk;

  eeprom_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .TIMEOUT (TO)
  ) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .REQ      (req),
    .RNW      (rnw),
    .ADDR_IN  (addr_in),
    .WDATA_IN (wdata_in),
    .GNT      (gnt),
    .DONE     (done),
    .ERR      (err),
    .RDATA    (rdata),
    .EE_WR    (ee_wr),
    .EE_RD    (ee_rd),
    .EE_ADDR  (ee_addr),
    .EE_WDATA (ee_wdata),
    .EE_DOE   (ee_doe),
    .EE_RDATA (ee_rdata),
    .EE_ACK   (ee_ack),
    .EE_RST   (ee_rst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction. lat = cycles from strobe to ACK; no ACK means timeout.
  task automatic serve(input int lat, input bit give_ack, input int drop_at, input bit keep);
    int          exp_who, cyc, exp_t;
    logic [1:0]  exp_gnt;
    logic [10:0] a;
    bit          ok, rd;
    exp_who = -1;
    for (int o = 0; o < NREQ; o++) begin
      int i;
      i = (ptr_m + o) % NREQ;
      if (exp_who < 0 && req[i]) exp_who = i;
    end
    cyc = 0;
    while (gnt === 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant_seen", {31'b0, gnt !== 2'b00}, 1);
    if (gnt === 2'b00 || exp_who < 0) return;
    exp_gnt = '0;
    exp_gnt[exp_who] = 1'b1;
    chk("gnt_winner", gnt, exp_gnt);
    ptr_m = (exp_who + 1) % NREQ;
    rd = c_rnw[exp_who];
    a  = c_addr[exp_who];

    @(negedge clk);
    chk("strobe", {ee_wr, ee_rd}, rd ? 2'b01 : 2'b10);
    chk("issue_addr", ee_addr, a);
    chk("issue_doe", ee_doe, !rd);
    if (!rd) chk("issue_wdata", ee_wdata, c_wdata[exp_who]);

    exp_t = give_ack ? lat + 1 : TO + 3;
    ok = 1'b1;
    for (int t = 1; t <= exp_t; t++) begin
      @(negedge clk);
      if (t < exp_t) begin
        if (ee_wr !== 1'b0 || ee_rd !== 1'b0 || done !== 2'b00) ok = 1'b0;
        if (gnt !== exp_gnt || ee_addr !== a) ok = 1'b0;
        if (ee_rst !== ((!give_ack && t > TO) ? 1'b1 : 1'b0)) ok = 1'b0;
        if (ee_doe !== ((t <= (give_ack ? lat : TO)) ? !rd : 1'b0)) ok = 1'b0;
      end
      if (t == drop_at) req[exp_who] = 1'b0;
      if (give_ack && t == lat) begin
        ee_ack = 1'b1;
        ee_rdata = rd ? mem[a] : 8'($urandom);
        if (rd) exp_rdata = mem[a];
        else    mem[a] = c_wdata[exp_who];
      end else begin
        ee_ack = 1'b0;
      end
    end
    chk("wait_hold", {31'b0, ok}, 1);
    chk("done_pulse", done, exp_gnt);
    chk("done_err", err, !give_ack);
    chk("done_rdata", rdata, exp_rdata);
    chk("done_ee_rst", ee_rst, 0);
    if (!keep) req = 2'b00;
    @(negedge clk);
    chk("post_done", {gnt, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench aborted");
  end

  initial begin
    int lat, drop, cyc;
    $display("eeprom_arbiter bench, device code %b", EE_DEV_CODE);
    req = 2'b00;
    ee_ack = 1'b0;
    ee_rdata = 8'h00;
    ptr_m = 0;
    exp_rdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      c_rnw[i] = 1'b0;
      c_addr[i] = '0;
      c_wdata[i] = '0;
    end
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[11'h7FF] = 8'h3C;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt_done_err", {gnt, done, err}, 0);
    chk("rst_strobes_doe", {ee_wr, ee_rd, ee_doe}, 0);
    chk("rst_ee_addr", ee_addr, 0);
    chk("rst_ee_wdata", ee_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ee_rst", ee_rst, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ee_rst", ee_rst, 0);

    // Single write with slow ACK
    c_rnw[0] = 1'b0; c_addr[0] = 11'h155; c_wdata[0] = 8'hA5;
    req = 2'b01;
    serve(60, 1'b1, -1, 1'b0);
    chk("write_landed", mem[11'h155], 8'hA5);

    // Single read
    c_rnw[1] = 1'b1; c_addr[1] = 11'h7FF;
    req = 2'b10;
    serve(5, 1'b1, -1, 1'b0);
    chk("read_3c", rdata, 8'h3C);

    // Stray ACK while idle
    ee_ack = 1'b1; ee_rdata = 8'hEE;
    @(negedge clk);
    ee_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_ack_quiet", {gnt, done, ee_wr, ee_rd}, 0);
    end
    chk("stray_ack_rdata", rdata, exp_rdata);

    // Persistent contention: alternating grants
    for (int i = 0; i < 2; i++) begin
      c_rnw[i] = 1'($urandom_range(0, 1));
      c_addr[i] = 11'($urandom_range(0, 2047));
      c_wdata[i] = 8'($urandom);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) serve($urandom_range(1, 12), 1'b1, -1, k < 3);

    // Randomized traffic, some requesters dropping REQ mid-operation
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 2; i++) begin
        c_rnw[i] = 1'($urandom_range(0, 1));
        c_addr[i] = 11'($urandom_range(0, 15));
        c_wdata[i] = 8'($urandom);
      end
      req = 2'($urandom_range(1, 3));
      lat = $urandom_range(1, 20);
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : -1;
      serve(lat, 1'b1, drop, 1'b0);
    end

    // Watchdog abort, then a normal read
    c_rnw[0] = 1'b0; c_addr[0] = 11'h0AA; c_wdata[0] = 8'h11;
    req = 2'b01;
    serve(0, 1'b0, -1, 1'b0);
    c_rnw[1] = 1'b1; c_addr[1] = 11'h0AA;
    req = 2'b10;
    serve(7, 1'b1, -1, 1'b0);

    // Asynchronous reset in the middle of a wait; pointer must return to 0
    c_rnw[0] = 1'b1; c_addr[0] = 11'h123;
    req = 2'b01;
    cyc = 0;
    while (gnt === 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_grant", gnt, 2'b01);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt_done_err", {gnt, done, err}, 0);
    chk("async_strobes_doe", {ee_wr, ee_rd, ee_doe}, 0);
    chk("async_ee_addr", ee_addr, 0);
    chk("async_rdata", rdata, 0);
    chk("async_ee_rst", ee_rst, 1);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    exp_rdata = 8'h00;
    c_rnw[0] = 1'b0; c_addr[0] = 11'h300; c_wdata[0] = 8'h5C;
    c_rnw[1] = 1'b1; c_addr[1] = 11'h300;
    req = 2'b11;
    serve(3, 1'b1, -1, 1'b1);
    serve(4, 1'b1, -1, 1'b0);
    chk("post_reset_read", rdata, 8'h5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
